// File: rtl/fc_layer_mem.sv
`default_nettype none
// =============================================================================
// Module   : fc_layer_mem
// Brief    : Ping-pong activation/weight memory for a fully connected layer
//            engine. Optional FC_MEM_CLEAR_EN zeroes the new write bank after
//            every swap.
// Revision : 1.0 - initial release
// =============================================================================
module fc_layer_mem #(
    parameter int DEPTH = 1024,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic [AW-1:0] layer_addr,
    input  logic          layer_we,
    input  logic [DW-1:0] layer_out,
    input  logic          layer_end,
    output logic          layer_enable,
    output logic [DW-1:0] input_value,
    output logic          busy,
    output logic          done,
    output logic          bank_sel,
    output logic          err
);

    localparam int              c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   c_DEPTH = AW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_done_nxt;
    logic               w_toggle;

    logic [DW-1:0]      r_mem_a [DEPTH];
    logic [DW-1:0]      r_mem_b [DEPTH];

    logic               w_host_ok;
    logic               w_layer_ok;
    logic [c_IW-1:0]    w_host_idx;
    logic [c_IW-1:0]    w_layer_idx;
    logic [DW-1:0]      w_rd_data;
    logic               w_err_set;

    logic               w_wr_en;
    logic               w_wr_bank;
    logic [c_IW-1:0]    w_wr_idx;
    logic [DW-1:0]      w_wr_data;

`ifdef FC_MEM_CLEAR_EN
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);
    logic [c_IW-1:0]    r_clr_cnt;
`endif

    assign w_host_ok    = (host_addr < c_DEPTH);
    assign w_layer_ok   = (layer_addr < c_DEPTH);
    assign w_host_idx   = host_addr[c_IW-1:0];
    assign w_layer_idx  = layer_addr[c_IW-1:0];
    assign w_rd_data    = bank_sel ? r_mem_b[w_layer_idx] : r_mem_a[w_layer_idx];

    assign layer_enable = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);

    // Every RUN cycle is a read, so an out-of-range engine address flags even without layer_we.
    assign w_err_set = (host_we  & ((r_state != S_IDLE) | ~w_host_ok))
                     | (layer_we & ((r_state != S_RUN)  | ~w_layer_ok))
                     | ((r_state == S_RUN) & ~w_layer_ok);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_toggle    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (layer_end) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_toggle = 1'b1;
`ifdef FC_MEM_CLEAR_EN
                w_state_nxt = S_CLEAR;
`else
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
`endif
            end
            S_CLEAR: begin
`ifdef FC_MEM_CLEAR_EN
                if (r_clr_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single write port per bank; the state decides who owns it this cycle.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_bank = bank_sel;
        w_wr_idx  = w_host_idx;
        w_wr_data = host_wdata;
        case (r_state)
            S_IDLE: begin
                w_wr_en = reset_n & host_we & w_host_ok;
            end
            S_RUN: begin
                w_wr_en   = reset_n & layer_we & w_layer_ok;
                w_wr_bank = ~bank_sel;
                w_wr_idx  = w_layer_idx;
                w_wr_data = layer_out;
            end
`ifdef FC_MEM_CLEAR_EN
            S_CLEAR: begin
                w_wr_en   = reset_n;
                w_wr_bank = ~bank_sel;
                w_wr_idx  = r_clr_cnt;
                w_wr_data = '0;
            end
`endif
            default: w_wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !w_wr_bank) begin
            r_mem_a[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && w_wr_bank) begin
            r_mem_b[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            input_value <= '0;
            done        <= 1'b0;
            bank_sel    <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            done    <= w_done_nxt;
            if (w_toggle) begin
                bank_sel <= ~bank_sel;
            end
            if (w_err_set) begin
                err <= 1'b1;
            end
            if (r_state == S_RUN) begin
                input_value <= w_layer_ok ? w_rd_data : '0;
            end
        end
    end

`ifdef FC_MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= (r_clr_cnt == c_LAST) ? '0 : r_clr_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_mem.sv
`default_nettype none
// =============================================================================
// Module   : tb_fc_layer_mem
// Brief    : Self-checking bench for fc_layer_mem with a per-cycle reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fc_layer_mem;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int AW    = 16;
`ifdef FC_MEM_CLEAR_EN
    localparam int SWAP_LAT = DEPTH + 2;
`else
    localparam int SWAP_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n, start, host_we, layer_we, layer_end;
    logic [AW-1:0] host_addr, layer_addr;
    logic [DW-1:0] host_wdata, layer_out;
    logic          layer_enable, busy, done, bank_sel, err;
    logic [DW-1:0] input_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_layer_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .layer_addr  (layer_addr),
        .layer_we    (layer_we),
        .layer_out   (layer_out),
        .layer_end   (layer_end),
        .layer_enable(layer_enable),
        .input_value (input_value),
        .busy        (busy),
        .done        (done),
        .bank_sel    (bank_sel),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: banks as plain arrays, swap progress as a countdown.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_val [2][DEPTH];
    bit            m_init = 0, m_run = 0, m_sel = 0, m_err = 0, m_done = 0, m_iv_known = 1;
    logic [DW-1:0] m_iv = '0;
    int            m_cd = 0;

    always @(posedge clk) begin
        m_done = 0;
        if (!reset_n) begin
            m_init = 1; m_run = 0; m_cd = 0; m_sel = 0; m_err = 0;
            m_iv = '0; m_iv_known = 1;
        end else if (m_init) begin
            if (m_run) begin
                if (host_we) m_err = 1;
                if (int'(layer_addr) < DEPTH) begin
                    m_iv       = m_mem[m_sel][int'(layer_addr)];
                    m_iv_known = m_val[m_sel][int'(layer_addr)];
                end else begin
                    m_iv = '0; m_iv_known = 1; m_err = 1;
                end
                if (layer_we) begin
                    if (int'(layer_addr) < DEPTH) begin
                        m_mem[!m_sel][int'(layer_addr)] = layer_out;
                        m_val[!m_sel][int'(layer_addr)] = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (layer_end) begin
                    m_run = 0;
                    m_cd  = SWAP_LAT - 1;
                end
            end else if (m_cd > 0) begin
                if (host_we || layer_we) m_err = 1;
                if (m_cd == SWAP_LAT - 1) begin
                    m_sel = !m_sel;
                end else begin
                    m_mem[!m_sel][DEPTH - m_cd] = '0;
                    m_val[!m_sel][DEPTH - m_cd] = 1;
                end
                m_cd--;
                if (m_cd == 0) m_done = 1;
            end else begin
                if (host_we) begin
                    if (int'(host_addr) < DEPTH) begin
                        m_mem[m_sel][int'(host_addr)] = host_wdata;
                        m_val[m_sel][int'(host_addr)] = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (layer_we) m_err = 1;
                if (start) m_run = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("cyc_layer_enable", layer_enable, m_run);
            chk("cyc_busy", busy, (m_run || m_cd > 0));
            chk("cyc_done", done, m_done);
            chk("cyc_bank_sel", bank_sel, m_sel);
            chk("cyc_err", err, m_err);
            if (m_iv_known) chk("cyc_input_value", input_value, m_iv);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int cyc = 1;
        while (!done && cyc < SWAP_LAT + 20) begin
            step();
            cyc++;
        end
        chk({name, "_latency"}, cyc, SWAP_LAT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp_a;
        reset_n = 0; start = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        layer_addr = '0; layer_we = 0; layer_out = '0; layer_end = 0;
        step(); step();
        chk("rst_input_value", input_value, 16'h0000);
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1;
        repeat (3) step();
        chk("idle_layer_enable", layer_enable, 0);

        // Engine write while idle is illegal
        layer_we = 1; step(); layer_we = 0;
        chk("idle_layer_we_err", err, 1);
        reset_n = 0; step(); reset_n = 1;
        chk("err_cleared_by_reset", err, 0);

        // Preload bank A
        host_we = 1;
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = AW'(i); host_wdata = DW'(16'h1000 + i); step();
        end
        host_addr = 5; host_wdata = 16'h0123; step();
        host_we = 0;

        // Run 1: read A[5], write B[3], same-cycle write+end on B[7]
        start = 1; step(); start = 0;
        chk("run1_enable", layer_enable, 1);
        layer_addr = 5; step();
        chk("run1_read_a5", input_value, 16'h0123);
        start = 1; layer_addr = 3; layer_we = 1; layer_out = 16'h7FFF; step();
        start = 0; layer_we = 0;
        chk("run1_read_a3", input_value, 16'h1003);
        layer_addr = 7; layer_we = 1; layer_out = 16'h0042; layer_end = 1; step();
        layer_we = 0; layer_end = 0; layer_addr = 0;
        chk("drain_enable_low", layer_enable, 0);
        wait_done("swap1");
        chk("swap1_bank_sel", bank_sel, 1);
        chk("swap1_err", err, 0);

        // Run 2: results of run 1 are now inputs
        step();
        start = 1; step(); start = 0;
        layer_addr = 3; step();
        chk("run2_read_b3", input_value, 16'h7FFF);
        layer_addr = 7; step();
        chk("run2_read_b7", input_value, 16'h0042);
        layer_addr = 0; layer_end = 1; step(); layer_end = 0;
        wait_done("swap2");
        chk("swap2_bank_sel", bank_sel, 0);

        // Run 3: bank A again (zeroed when clearing is built in)
        start = 1; step(); start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            layer_addr = AW'(i); step();
`ifdef FC_MEM_CLEAR_EN
            exp_a = 16'h0000;
`else
            exp_a = (i == 5) ? 16'h0123 : DW'(16'h1000 + i);
`endif
            chk("run3_read_a", input_value, exp_a);
        end

        // Illegal accesses inside run 3
        host_we = 1; host_addr = 2; host_wdata = 16'hBEEF; layer_addr = 2; step();
        host_we = 0;
        chk("host_we_run_err", err, 1);
        step();
`ifdef FC_MEM_CLEAR_EN
        chk("host_we_dropped", input_value, 16'h0000);
`else
        chk("host_we_dropped", input_value, 16'h1002);
`endif
        layer_addr = AW'(DEPTH); step();
        chk("oob_read_zero", input_value, 16'h0000);
        chk("oob_read_err", err, 1);
        layer_addr = 0; layer_end = 1; step(); layer_end = 0;
        wait_done("swap3");
        step(); step();
        chk("err_sticky", err, 1);

        // Reset in the middle of a run aborts without a swap
        start = 1; step(); start = 0; step();
        reset_n = 0; step(); reset_n = 1;
        chk("abort_busy", busy, 0);
        chk("abort_bank_sel", bank_sel, 0);
        chk("abort_err", err, 0);
        repeat (SWAP_LAT + 2) begin
            step();
            chk("abort_no_done", done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_mem.md
Name: fc_layer_mem

Overview:
- Ping-pong activation/weight memory that sits on the memory side of a fully connected layer engine.
- Answers the engine's address-driven reads on `input_value`.
- Captures the engine's result writes (`we`/`out`/`addr`).
- Drives the engine's `enable`, and swaps banks when the engine raises `layer_end`, so the results of one layer become the inputs of the next.
- A host port preloads front-cell values and weights between layers.

Parameters:
- DEPTH, 1024, words per bank (addresses 0..DEPTH-1 valid)
- DW, 16, data width (signed Q-format word, passed through unmodified)
- AW, 16, address width of host and layer address ports

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- start  in  1  pulse: begin one layer operation
- host_we  in  1  host write strobe into the read bank
- host_addr  in  AW  host write address
- host_wdata  in  DW  host write data
- layer_addr  in  AW  engine address (read or write)
- layer_we  in  1  engine write enable
- layer_out  in  DW  engine write data
- layer_end  in  1  engine layer-complete level
- layer_enable  out  1  enable to engine
- input_value  out  DW  registered read data to engine
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after bank swap completes
- bank_sel  out  1  current read bank (0=A, 1=B); write bank is ~bank_sel
- err  out  1  sticky: illegal access seen, cleared only by reset

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE.
  - layer_enable=0, input_value=0, busy=0, done=0, bank_sel=0, err=0, clear counter=0.
  - Memory contents are not reset.
  - Reset mid-RUN aborts immediately; no swap occurs.
- States: IDLE, RUN, DRAIN, CLEAR (macro only).
- IDLE:
  - Host writes go to the read bank.
  - start=1 -> RUN, with layer_enable=1 from the next cycle.
  - start while busy is ignored.
- RUN:
  - layer_enable=1.
  - Reads: input_value <= readbank[layer_addr], 1-cycle latency, updated every cycle regardless of layer_we.
  - Writes: layer_we=1 -> writebank[layer_addr] <= layer_out.
  - layer_end=1 -> DRAIN, layer_enable=0 on that transition.
  - host_we in RUN: write dropped, err<=1.
- DRAIN:
  - Lasts exactly one cycle, so the engine sees enable low and clears layer_end.
  - Then bank_sel toggles -> IDLE with done=1 for one cycle.
- Simultaneous layer_we and layer_end in the same RUN cycle: the write is committed before the swap.
- Layer writes outside RUN: ignored, err<=1.
- Out of range (address >= DEPTH):
  - Write: dropped, err<=1.
  - Read: returns 0, err<=1.
- Read and write never target the same bank, so no read/write collision exists.
- Data is never modified; no arithmetic on stored words.

Optional Feature:
- FC_MEM_CLEAR_EN defined:
  - DRAIN -> CLEAR instead of IDLE.
  - CLEAR writes 0 to every word of the new write bank (the old read bank), one word per cycle, addresses 0..DEPTH-1.
  - The cycle after the last word: bank_sel already toggled at DRAIN exit, done=1, -> IDLE.
  - start and host_we during CLEAR: start ignored; host_we sets err.
  - Total swap latency DEPTH+2 cycles from layer_end.
- FC_MEM_CLEAR_EN undefined:
  - No CLEAR state; swap latency 2 cycles from layer_end.
  - Stale data remains in the write bank.

Test Plan:
- Reset then idle: reset_n=0 two cycles -> all outputs 0, bank_sel=0; start not asserted -> layer_enable stays 0.
- Host load and read: host writes A[5]=16'h0123, start; engine drives layer_addr=5 -> input_value=16'h0123 exactly one cycle later.
- Engine write and swap: in RUN, layer_we with addr 3, data 16'h7FFF; layer_end -> DRAIN, then done pulse, bank_sel=1; next run reading addr 3 returns 16'h7FFF.
- Illegal access: host_we during RUN, and layer_addr=DEPTH read -> write not committed, input_value=0, err=1 and stays 1 until reset.
- Same-cycle write and end: layer_we=1 addr 7 data 16'h0042 with layer_end=1 -> after swap, addr 7 reads 16'h0042.
- Clear (FC_MEM_CLEAR_EN, DEPTH=8): preload bank A with nonzeros, run, end -> done exactly 10 cycles after layer_end; all 8 words of bank A read 0.
